arb_request_buffer: RTL and testbench

//  Upstream stage of the 2-line request/grant arbiter. Buffers transactions from two

---
 rtl/arb_request_buffer.sv | 151 +++++++++++++++
 tb/tb_arb_request_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_request_buffer.sv
// Two-client request buffer: per-channel FIFOs drive R0/R1, and each accepted grant pops one entry.
// Optional starvation monitor is enabled by defining ARB_REQ_STARVE_EN.
module arb_request_buffer #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int AW           = 2,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              R0,
    output logic              R1,
    input  logic              G0,
    input  logic              G1,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              grant_err,
    output logic [1:0]        starve
);

    if (DEPTH != (1 << AW) || DEPTH < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("arb_request_buffer: DEPTH must equal 2**AW (>= 2) and STARVE_LIMIT must be >= 1");
    end

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0]             w_in_valid;
    logic [1:0]             w_grant;
    logic [1:0]             w_req;
    logic [1:0]             w_ready;
    logic [1:0]             w_push;
    logic [1:0]             w_pop;
    logic [1:0]             w_starve;
    logic                   w_grant_err;
    logic [1:0][DATA_W-1:0] w_in_data;
    logic [1:0][DATA_W-1:0] w_rd_data;

    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_out_data;
    logic                   r_out_src;
    logic                   r_grant_err;

    assign w_in_valid = {in1_valid, in0_valid};
    assign w_in_data  = {in1_data, in0_data};
    assign w_grant    = {G1, G0};

    // Channel 0 wins a double grant; channel 1's grant is then ignored.
    assign w_pop[0] = w_grant[0] & w_req[0];
    assign w_pop[1] = w_grant[1] & w_req[1] & ~w_grant[0];
    assign w_push   = w_in_valid & w_ready;

    assign w_grant_err = (&w_grant)
                       | (w_grant[0] & ~w_req[0])
                       | (w_grant[1] & ~w_req[1]);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [AW:0]       r_count;
            logic [AW-1:0]     r_wr_ptr;
            logic [AW-1:0]     r_rd_ptr;
            logic [DATA_W-1:0] r_mem [DEPTH];

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_count  <= '0;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Storage is not reset; the pointers alone decide what is valid.
            always_ff @(posedge clock) begin
                if (w_push[gi]) r_mem[r_wr_ptr] <= w_in_data[gi];
            end

            assign w_req[gi]     = (r_count != '0);
            assign w_ready[gi]   = (r_count != FULL_CNT);
            assign w_rd_data[gi] = r_mem[r_rd_ptr];

`ifdef ARB_REQ_STARVE_EN
            localparam int SW = $clog2(STARVE_LIMIT + 1);
            logic [SW-1:0] r_starve_cnt;
            logic          r_starve;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_starve_cnt <= '0;
                    r_starve     <= 1'b0;
                end else begin
                    if (!w_req[gi] || w_grant[gi])
                        r_starve_cnt <= '0;
                    else if (r_starve_cnt != SW'(STARVE_LIMIT))
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    if (r_starve_cnt == SW'(STARVE_LIMIT))
                        r_starve <= 1'b1;
                end
            end

            assign w_starve[gi] = r_starve;
`else
            assign w_starve[gi] = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_grant_err <= 1'b0;
        end else begin
            r_out_valid <= |w_pop;
            if (w_pop[0]) begin
                r_out_data <= w_rd_data[0];
                r_out_src  <= 1'b0;
            end else if (w_pop[1]) begin
                r_out_data <= w_rd_data[1];
                r_out_src  <= 1'b1;
            end
            if (w_grant_err) r_grant_err <= 1'b1;
        end
    end

    assign in0_ready = w_ready[0];
    assign in1_ready = w_ready[1];
    assign R0        = w_req[0];
    assign R1        = w_req[1];
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign grant_err = r_grant_err;
    assign starve    = w_starve;

endmodule

// File: tb/tb_arb_request_buffer.sv
// Directed bench for arb_request_buffer: reset, single transfer, back-pressure, wrap, grant errors, starvation.
module tb_arb_request_buffer;

    localparam int DATA_W = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in0_valid = 1'b0;
    logic [DATA_W-1:0] in0_data = '0;
    logic              in0_ready;
    logic              in1_valid = 1'b0;
    logic [DATA_W-1:0] in1_data = '0;
    logic              in1_ready;
    logic              R0, R1;
    logic              G0 = 1'b0;
    logic              G1 = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              grant_err;
    logic [1:0]        starve;

    int total = 0;
    int bad   = 0;

    arb_request_buffer #(.DATA_W(8), .DEPTH(4), .AW(2), .STARVE_LIMIT(15)) dut (
        .clock(clock), .reset(reset),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .R0(R0), .R1(R1), .G0(G0), .G1(G1),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .grant_err(grant_err), .starve(starve)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance past the next rising edge so outputs reflect that edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] starve_exp;
`ifdef ARB_REQ_STARVE_EN
        starve_exp = 2'b10;
`else
        starve_exp = 2'b00;
`endif

        // Reset values
        #12;
        chk("rst_R0", R0, 0);
        chk("rst_R1", R1, 0);
        chk("rst_rdy0", in0_ready, 1);
        chk("rst_rdy1", in1_ready, 1);
        chk("rst_oval", out_valid, 0);
        chk("rst_gerr", grant_err, 0);
        chk("rst_starve", starve, 0);
        reset = 1'b1;
        tick();

        // 1: reset mid-operation with 3 entries held and out_valid high
        in0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in0_data = 8'h60 + 8'(i);
            tick();
        end
        in0_valid = 1'b0;
        chk("t1_full_rdy0", in0_ready, 0);
        G0 = 1'b1;
        tick();
        G0 = 1'b0;
        chk("t1_pre_oval", out_valid, 1);
        chk("t1_pre_odata", out_data, 8'h60);
        #2 reset = 1'b0;
        #1;
        chk("t1_R0", R0, 0);
        chk("t1_rdy0", in0_ready, 1);
        chk("t1_oval", out_valid, 0);
        chk("t1_odata", out_data, 0);
        #2 reset = 1'b1;
        G0 = 1'b1;
        tick();
        G0 = 1'b0;
        chk("t1_post_oval", out_valid, 0);
        chk("t1_post_R0", R0, 0);
        chk("t1_gerr_noreq", grant_err, 1);
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t1_gerr_cleared", grant_err, 0);
        tick();

        // 2: single transfer
        in0_valid = 1'b1;
        in0_data  = 8'hA5;
        tick();
        in0_valid = 1'b0;
        chk("t2_R0_up", R0, 1);
        G0 = 1'b1;
        tick();
        G0 = 1'b0;
        chk("t2_oval", out_valid, 1);
        chk("t2_odata", out_data, 8'hA5);
        chk("t2_osrc", out_src, 0);
        chk("t2_R0_down", R0, 0);
        tick();
        chk("t2_oval_drop", out_valid, 0);
        chk("t2_odata_hold", out_data, 8'hA5);

        // 3: full / back-pressure on ch1
        in1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1_data = 8'h10 + 8'(i);
            tick();
        end
        chk("t3_rdy1_full", in1_ready, 0);
        in1_data = 8'h99;
        tick();
        in1_valid = 1'b0;
        chk("t3_rdy1_still", in1_ready, 0);
        G1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3_oval%0d", i), out_valid, 1);
            chk($sformatf("t3_odata%0d", i), out_data, 8'h10 + i);
            chk($sformatf("t3_osrc%0d", i), out_src, 1);
        end
        G1 = 1'b0;
        chk("t3_R1_down", R1, 0);
        chk("t3_rdy1_free", in1_ready, 1);
        tick();
        chk("t3_no_5th", out_valid, 0);

        // 4: concurrent push + pop across pointer wrap
        in0_valid = 1'b1;
        in0_data  = 8'h20;
        tick();
        in0_data  = 8'h21;
        tick();
        G0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in0_data = 8'h22 + 8'(i);
            tick();
            chk($sformatf("t4_oval%0d", i), out_valid, 1);
            chk($sformatf("t4_odata%0d", i), out_data, 8'h20 + i);
            chk($sformatf("t4_R0_%0d", i), R0, 1);
            chk($sformatf("t4_rdy0_%0d", i), in0_ready, 1);
        end
        in0_valid = 1'b0;
        tick();
        chk("t4_drain0", out_data, 8'h2A);
        tick();
        chk("t4_drain1", out_data, 8'h2B);
        G0 = 1'b0;
        chk("t4_R0_empty", R0, 0);
        chk("t4_gerr_clean", grant_err, 0);

        // 5: grant errors
        in0_valid = 1'b1; in0_data = 8'h30;
        in1_valid = 1'b1; in1_data = 8'h40;
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        G0 = 1'b1; G1 = 1'b1;
        tick();
        G0 = 1'b0; G1 = 1'b0;
        chk("t5_oval", out_valid, 1);
        chk("t5_odata", out_data, 8'h30);
        chk("t5_osrc", out_src, 0);
        chk("t5_R1_kept", R1, 1);
        chk("t5_gerr", grant_err, 1);
        tick();
        chk("t5_gerr_sticky", grant_err, 1);
        G1 = 1'b1;
        tick();
        chk("t5_ch1_data", out_data, 8'h40);
        chk("t5_ch1_src", out_src, 1);
        tick();
        G1 = 1'b0;
        chk("t5_empty_noval", out_valid, 0);

        // 6: starvation on ch1
        in1_valid = 1'b1; in1_data = 8'h50;
        tick();
        in1_valid = 1'b0;
        tick();
        chk("t6_early", starve, 0);
        repeat (20) tick();
        chk("t6_starve", starve, starve_exp);
        G1 = 1'b1;
        tick();
        G1 = 1'b0;
        tick();
        chk("t6_sticky", starve, starve_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
